// File: rtl/digit_serial_subtractor_32bit.sv
// digit_serial_subtractor_32bit
//   Digit-serial subtractor. It computes Diff = A - B - Bin and processes DIGIT
//   bits per clock, starting with the least-significant digit. One operation is
//   in flight at a time, and both sides use a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   A/B/Bin valid          in_ready   block idle, accepts an operation
//   A, B       minuend / subtrahend   Bin        borrow in
//   out_valid  result valid           out_ready  consumer takes the result
//   Diff       (A - B - Bin) mod 2^WIDTH
//   Bout       unsigned borrow out (A < B + Bin)
//   Ovf        two's-complement overflow
//
// Latency: out_valid rises N = WIDTH/DIGIT edges after the accept edge.
module digit_serial_subtractor_32bit #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((DIGIT < 1) || (DIGIT > WIDTH) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
            $error("DIGIT must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q, diff_q, diff_nx;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic             sa_q, sb_q;
    logic [DIGIT:0]   step;
    logic             last;

    // One digit step in DIGIT+1 bits. A negative result wraps so that the top
    // bit is set, and that top bit is exactly the borrow out of this digit.
    assign step = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]}
                - {{DIGIT{1'b0}}, borrow_q};
    assign last = (cnt_q == CW'(N - 1));

    // The digit result enters from the MSB side. After N steps the first
    // digit has reached bit 0.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign diff_nx = step[DIGIT-1:0];
        end else begin : g_shift
            assign diff_nx = {step[DIGIT-1:0], diff_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= A;
                        b_q      <= B;
                        borrow_q <= Bin;
                        cnt_q    <= '0;
                        sa_q     <= A[WIDTH-1];
                        sb_q     <= B[WIDTH-1];
                    end
                end
                RUN: begin
                    diff_q   <= diff_nx;
                    a_q      <= a_q >> DIGIT;
                    b_q      <= b_q >> DIGIT;
                    borrow_q <= step[DIGIT];
                    cnt_q    <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Diff comes straight from its register. Bout and Ovf are gated by DONE,
    // so they read 0 in every other state.
    assign Diff = diff_q;
    assign Bout = (state == DONE) & borrow_q;
    assign Ovf  = (state == DONE) & (sa_q != sb_q) & (diff_q[WIDTH-1] != sa_q);

endmodule

// File: tb/tb_digit_serial_subtractor_32bit.sv
// Scoreboard bench for digit_serial_subtractor_32bit.
// The main instance (DIGIT=4) runs the directed cases. Four further instances
// (DIGIT 1/4/8/32) run random traffic against a golden A-B-Bin model, with
// random out_ready.
module tb_digit_serial_subtractor_32bit;

    localparam int OPS = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] d;
        logic        bo;
        logic        ov;
    } res_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic res_t golden(input logic [31:0] a, input logic [31:0] b, input logic bin);
        logic [32:0] r;
        res_t        o;
        r    = {1'b0, a} - {1'b0, b} - {32'd0, bin};
        o.d  = r[31:0];
        o.bo = r[32];
        o.ov = (a[31] != b[31]) && (r[31] != a[31]);
        return o;
    endfunction

    // ---------------- main instance, directed ----------------
    logic        iv, irdy, ov, ordy, bin, bout, ovf;
    logic [31:0] a, b, diff;
    res_t        q0[$];

    digit_serial_subtractor_32bit #(.WIDTH(32), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(irdy),
        .A(a), .B(b), .Bin(bin),
        .out_valid(ov), .out_ready(ordy),
        .Diff(diff), .Bout(bout), .Ovf(ovf)
    );

    always @(negedge clk) begin
        res_t e;
        if (!rst && ov && ordy) begin
            chk("main pending", q0.size() != 0, 1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("main result", {diff, bout, ovf}, e);
            end
        end
    end

    task automatic issue(input logic [31:0] ai, input logic [31:0] bi, input logic bini,
                         input res_t e, input string nm);
        int n;
        @(negedge clk);
        a = ai; b = bi; bin = bini; iv = 1'b1;
        chk({nm, " in_ready"}, irdy, 1);
        q0.push_back(e);
        @(posedge clk); #1 iv = 1'b0;
        n = 0;
        while (!ov && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " latency"}, n, 8);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " Diff"},      diff, 0);
        chk({nm, " Bout"},      bout, 0);
        chk({nm, " Ovf"},       ovf,  0);
        chk({nm, " out_valid"}, ov,   0);
        chk({nm, " in_ready"},  irdy, 1);
    endtask

    // ---------------- random lanes ----------------
    logic rand_go = 1'b0;

    for (genvar g = 0; g < 4; g++) begin : lane
        localparam int D = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 32;
        logic        liv, lirdy, lov, lordy, lbin, lbo, lovf;
        logic        done = 1'b0;
        logic [31:0] la, lb, ld;
        res_t        lq[$];
        int          got = 0;

        digit_serial_subtractor_32bit #(.WIDTH(32), .DIGIT(D)) u (
            .clk(clk), .rst(rst), .in_valid(liv), .in_ready(lirdy),
            .A(la), .B(lb), .Bin(lbin),
            .out_valid(lov), .out_ready(lordy),
            .Diff(ld), .Bout(lbo), .Ovf(lovf)
        );

        initial begin
            lordy = 1'b1;
            forever begin
                @(posedge clk); #1 lordy = ($urandom_range(0, 3) != 0);
            end
        end

        always @(negedge clk) begin
            res_t e;
            if (!rst && lov && lordy) begin
                chk("lane pending", lq.size() != 0, 1);
                if (lq.size() != 0) begin
                    e = lq.pop_front();
                    chk("lane result", {ld, lbo, lovf}, e);
                end
                got++;
            end
        end

        initial begin
            int t;
            liv = 1'b0; la = '0; lb = '0; lbin = 1'b0;
            wait (rand_go);
            for (int k = 0; k < OPS; k++) begin
                @(negedge clk);
                case (k % 6)
                    0:       begin la = 32'h0;        lb = 32'hFFFFFFFF; end
                    1:       begin la = 32'h80000000; lb = $urandom();   end
                    2:       begin la = $urandom();   lb = la;           end
                    default: begin la = $urandom();   lb = $urandom();   end
                endcase
                lbin = $urandom_range(0, 1);
                liv  = 1'b1;
                t = 0;
                while (!lirdy && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                chk("lane accept", lirdy, 1);
                if (lirdy) lq.push_back(golden(la, lb, lbin));
                @(posedge clk); #1 liv = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            t = 0;
            while (got < OPS && t < 500) begin
                @(negedge clk);
                t++;
            end
            chk("lane drained", got, OPS);
            done = 1'b1;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        iv = 1'b0; a = '0; b = '0; bin = 1'b0; ordy = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk) rst = 1'b0;

        issue(32'd5,        32'd3,        1'b0, res_t'{32'h00000002, 1'b0, 1'b0}, "5-3 first");
        @(posedge clk); #1;
        issue(32'd5,        32'd3,        1'b0, res_t'{32'h00000002, 1'b0, 1'b0}, "5-3");
        @(posedge clk); #1;
        issue(32'd0,        32'd1,        1'b0, res_t'{32'hFFFFFFFF, 1'b1, 1'b0}, "0-1");
        @(posedge clk); #1;
        issue(32'h80000000, 32'd1,        1'b0, res_t'{32'h7FFFFFFF, 1'b0, 1'b1}, "min-1");
        @(posedge clk); #1;
        issue(32'd0,        32'hFFFFFFFF, 1'b1, res_t'{32'h00000000, 1'b1, 1'b0}, "0-max-1");
        @(posedge clk); #1;

        // Backpressure: hold the result for five cycles and poke in_valid meanwhile.
        ordy = 1'b0;
        issue(32'h12345678, 32'h0F0F0F0F, 1'b1, res_t'{32'h03254768, 1'b0, 1'b0}, "bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp hold Diff",      diff, 32'h03254768);
            chk("bp hold Bout",      bout, 0);
            chk("bp hold Ovf",       ovf,  0);
            chk("bp hold out_valid", ov,   1);
            chk("bp hold in_ready",  irdy, 0);
            if (i == 1) begin a = 32'd1; b = 32'd1; iv = 1'b1; end
            if (i == 3) iv = 1'b0;
        end
        @(posedge clk); #1 ordy = 1'b1;
        @(posedge clk); #1;
        chk("bp release out_valid", ov,   0);
        chk("bp release in_ready",  irdy, 1);
        issue(32'd7, 32'd9, 1'b0, res_t'{32'hFFFFFFFE, 1'b1, 1'b0}, "7-9");
        @(posedge clk); #1;

        // Reset three cycles into RUN: the operation is aborted with no output.
        @(negedge clk);
        a = 32'hDEADBEEF; b = 32'h01234567; bin = 1'b0; iv = 1'b1;
        chk("abort in_ready", irdy, 1);
        @(posedge clk); #1 iv = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk_reset_outputs("abort");
        @(negedge clk) rst = 1'b0;
        issue(32'd10, 32'd4, 1'b0, res_t'{32'h00000006, 1'b0, 1'b0}, "10-4");
        @(posedge clk); #1;
        chk("main queue empty", q0.size(), 0);

        rand_go = 1'b1;
        cyc = 0;
        while (!(lane[0].done && lane[1].done && lane[2].done && lane[3].done) && cyc < 80000) begin
            @(negedge clk);
            cyc++;
        end
        chk("lanes finished", lane[0].done && lane[1].done && lane[2].done && lane[3].done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
